// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares PORT_NUM regfile write ports among REQ_NUM FU
// writeback requesters with a one-entry skid buffer each, round-robin priority and squash filtering.

module wb_port_arbiter_chk #(
    parameter int REQ_NUM  = 6,
    parameter int PORT_NUM = 4
) (
    input logic                clk,
    input logic                rst,
    input logic [PORT_NUM-1:0] i_wb_vld,
    input logic [REQ_NUM-1:0]  i_req_stall,
    input logic                i_conflict
);
    logic [PORT_NUM:0] w_vld_inc;

    assign w_vld_inc = {1'b0, i_wb_vld} + {{PORT_NUM{1'b0}}, 1'b1};

    // Winners are packed onto ports from port 0 upward.
    a_port_packed: assert property (@(posedge clk) disable iff (rst)
        (({1'b0, i_wb_vld} & w_vld_inc) == {(PORT_NUM+1){1'b0}}));

    // A loser is always buffered, so the conflict pulse and a raised stall coincide.
    a_conflict_stall: assert property (@(posedge clk) disable iff (rst)
        (i_conflict == (|i_req_stall)));

    // Nothing loses while a port is left idle.
    a_conflict_full: assert property (@(posedge clk) disable iff (rst)
        (!i_conflict || (&i_wb_vld)));
endmodule

module wb_port_arbiter #(
    parameter int REQ_NUM  = 6,
    parameter int PORT_NUM = 4,
    parameter int IPR_W    = 7,
    parameter int XLEN     = 64,
    parameter int ROB_W    = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [REQ_NUM-1:0]            i_req_vld,
    input  logic [REQ_NUM*IPR_W-1:0]      i_req_iprd,
    input  logic [REQ_NUM*XLEN-1:0]       i_req_data,
    input  logic [REQ_NUM*(ROB_W+1)-1:0]  i_req_rob,
    output logic [REQ_NUM-1:0]            o_req_stall,
    input  logic                          i_squash_vld,
    input  logic [ROB_W:0]                i_squash_rob,
    output logic [PORT_NUM-1:0]           o_wb_vld,
    output logic [PORT_NUM*IPR_W-1:0]     o_wb_iprd,
    output logic [PORT_NUM*XLEN-1:0]      o_wb_data,
    output logic                          o_conflict
);
    localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
    localparam int CNT_W = $clog2(PORT_NUM + 1);
    localparam int PSL_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    // e is younger than s: same wrap flag compares indices directly, otherwise inverted.
    function automatic logic is_younger(input logic [ROB_W:0] e, input logic [ROB_W:0] s);
        logic r;
        if (e[ROB_W] == s[ROB_W]) begin
            r = (e[ROB_W-1:0] > s[ROB_W-1:0]);
        end else begin
            r = (e[ROB_W-1:0] < s[ROB_W-1:0]);
        end
        return r;
    endfunction

    logic [REQ_NUM-1:0]         r_buf_vld;
    logic [IPR_W-1:0]           r_buf_iprd [REQ_NUM];
    logic [XLEN-1:0]            r_buf_data [REQ_NUM];
    logic [ROB_W:0]             r_buf_rob  [REQ_NUM];
    logic [PTR_W-1:0]           r_rr_ptr;
    logic [PORT_NUM-1:0]        r_wb_vld;
    logic [PORT_NUM*IPR_W-1:0]  r_wb_iprd;
    logic [PORT_NUM*XLEN-1:0]   r_wb_data;
    logic                       r_conflict;

    logic [REQ_NUM-1:0]         w_slot_vld;
    logic [IPR_W-1:0]           w_slot_iprd [REQ_NUM];
    logic [XLEN-1:0]            w_slot_data [REQ_NUM];
    logic [ROB_W:0]             w_slot_rob  [REQ_NUM];
    logic [REQ_NUM-1:0]         w_surv;
    logic [REQ_NUM-1:0]         w_grant;
    logic [REQ_NUM-1:0]         w_lose;
    logic [PORT_NUM-1:0]        w_port_vld;
    logic [IPR_W-1:0]           w_port_iprd [PORT_NUM];
    logic [XLEN-1:0]            w_port_data [PORT_NUM];
    logic [PTR_W-1:0]           w_rr_nxt;

    // Slot select and squash filter; a live input only reaches here while unstalled,
    // because stall mirrors buf_vld and a valid buffer takes the slot.
    always_comb begin
        w_slot_vld = '0;
        w_surv     = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (r_buf_vld[i]) begin
                w_slot_vld[i]  = 1'b1;
                w_slot_iprd[i] = r_buf_iprd[i];
                w_slot_data[i] = r_buf_data[i];
                w_slot_rob[i]  = r_buf_rob[i];
            end else begin
                w_slot_vld[i]  = i_req_vld[i];
                w_slot_iprd[i] = i_req_iprd[i*IPR_W +: IPR_W];
                w_slot_data[i] = i_req_data[i*XLEN +: XLEN];
                w_slot_rob[i]  = i_req_rob[i*(ROB_W+1) +: (ROB_W+1)];
            end
            w_surv[i] = w_slot_vld[i] &&
                        !(i_squash_vld && is_younger(w_slot_rob[i], i_squash_rob));
        end
    end

    // Round-robin scan from rr_ptr; the k-th surviving slot goes to port k.
    always_comb begin
        logic [PTR_W:0]   sum;
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] last;
        logic [CNT_W-1:0] cnt;
        sum        = '0;
        idx        = '0;
        last       = r_rr_ptr;
        cnt        = '0;
        w_grant    = '0;
        w_port_vld = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            w_port_iprd[p] = '0;
            w_port_data[p] = '0;
        end
        for (int k = 0; k < REQ_NUM; k++) begin
            sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(REQ_NUM)) begin
                idx = PTR_W'(sum - (PTR_W+1)'(REQ_NUM));
            end else begin
                idx = PTR_W'(sum);
            end
            if (w_surv[idx] && (cnt < CNT_W'(PORT_NUM))) begin
                w_grant[idx]                    = 1'b1;
                w_port_vld[PSL_W'(cnt)]  = 1'b1;
                w_port_iprd[PSL_W'(cnt)] = w_slot_iprd[idx];
                w_port_data[PSL_W'(cnt)] = w_slot_data[idx];
                last = idx;
                cnt  = cnt + CNT_W'(1);
            end else begin
                cnt = cnt;
            end
        end
        if (cnt == CNT_W'(0)) begin
            w_rr_nxt = r_rr_ptr;
        end else if (last == PTR_W'(REQ_NUM - 1)) begin
            w_rr_nxt = '0;
        end else begin
            w_rr_nxt = last + PTR_W'(1);
        end
        w_lose = w_surv & ~w_grant;
    end

    // Control state and registered write ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_vld  <= '0;
            r_rr_ptr   <= '0;
            r_wb_vld   <= '0;
            r_wb_iprd  <= '0;
            r_wb_data  <= '0;
            r_conflict <= 1'b0;
        end else begin
            r_buf_vld  <= w_lose;
            r_rr_ptr   <= w_rr_nxt;
            r_wb_vld   <= w_port_vld;
            r_conflict <= |w_lose;
            for (int p = 0; p < PORT_NUM; p++) begin
                r_wb_iprd[p*IPR_W +: IPR_W] <= w_port_iprd[p];
                r_wb_data[p*XLEN +: XLEN]   <= w_port_data[p];
            end
        end
    end

    // Skid payload capture for losers; qualified by r_buf_vld so needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < REQ_NUM; i++) begin
            if (w_lose[i]) begin
                r_buf_iprd[i] <= w_slot_iprd[i];
                r_buf_data[i] <= w_slot_data[i];
                r_buf_rob[i]  <= w_slot_rob[i];
            end
        end
    end

    assign o_req_stall = r_buf_vld;
    assign o_wb_vld    = r_wb_vld;
    assign o_wb_iprd   = r_wb_iprd;
    assign o_wb_data   = r_wb_data;
    assign o_conflict  = r_conflict;

    wb_port_arbiter_chk #(
        .REQ_NUM  (REQ_NUM),
        .PORT_NUM (PORT_NUM)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .i_wb_vld    (r_wb_vld),
        .i_req_stall (r_buf_vld),
        .i_conflict  (r_conflict)
    );
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed scenarios then random traffic,
// expectations from a list-based reference model of the arbitration rules.
module tb_wb_port_arbiter;
    localparam int R  = 6;
    localparam int P  = 4;
    localparam int IW = 7;
    localparam int DW = 64;
    localparam int RW = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic [R-1:0]    req_vld;
    logic [R*IW-1:0] req_iprd;
    logic [R*DW-1:0] req_data;
    logic [R*RW-1:0] req_rob;
    logic [R-1:0]    req_stall;
    logic            sq_vld;
    logic [RW-1:0]   sq_rob;
    logic [P-1:0]    wb_vld;
    logic [P*IW-1:0] wb_iprd;
    logic [P*DW-1:0] wb_data;
    logic            conflict;

    wb_port_arbiter #(.REQ_NUM(R), .PORT_NUM(P), .IPR_W(IW), .XLEN(DW), .ROB_W(RW-1)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_req_vld    (req_vld),
        .i_req_iprd   (req_iprd),
        .i_req_data   (req_data),
        .i_req_rob    (req_rob),
        .o_req_stall  (req_stall),
        .i_squash_vld (sq_vld),
        .i_squash_rob (sq_rob),
        .o_wb_vld     (wb_vld),
        .o_wb_iprd    (wb_iprd),
        .o_wb_data    (wb_data),
        .o_conflict   (conflict)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [P-1:0]    vld;
        logic [P*IW-1:0] iprd;
        logic [P*DW-1:0] data;
        logic [R-1:0]    stall;
        logic            conflict;
        bit              is_rst;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // reference model state: pending (buffered) entry per requester and priority start
    bit            m_pend [R];
    logic [IW-1:0] m_iprd [R];
    logic [DW-1:0] m_data [R];
    logic [RW-1:0] m_rob  [R];
    int            m_rr;
    logic [RW-1:0] dir_rob [R];

    // ROB positions live on a 2^RW circle; "younger" means 1..half-circle ahead.
    function automatic bit younger(input logic [RW-1:0] e, input logic [RW-1:0] s);
        logic [RW-1:0] d;
        d = e - s;
        return (d >= 7'd1) && (d <= 7'd63);
    endfunction

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic model_step();
        exp_t          e;
        int            order[$];
        int            n;
        bit            sv   [R];
        logic [IW-1:0] si   [R];
        logic [DW-1:0] sd   [R];
        logic [RW-1:0] sr   [R];
        e.vld = '0; e.iprd = '0; e.data = '0; e.stall = '0; e.conflict = 1'b0; e.is_rst = 1'b0;
        if (rst) begin
            for (int i = 0; i < R; i++) m_pend[i] = 1'b0;
            m_rr = 0;
            e.is_rst = 1'b1;
            sb_q.push_back(e);
            return;
        end
        for (int i = 0; i < R; i++) begin
            if (m_pend[i]) begin
                sv[i] = 1'b1; si[i] = m_iprd[i]; sd[i] = m_data[i]; sr[i] = m_rob[i];
            end else begin
                sv[i] = req_vld[i];
                si[i] = req_iprd[i*IW +: IW];
                sd[i] = req_data[i*DW +: DW];
                sr[i] = req_rob[i*RW +: RW];
            end
        end
        for (int k = 0; k < R; k++) begin
            int j;
            j = (m_rr + k) % R;
            if (sv[j] && !(sq_vld && younger(sr[j], sq_rob))) order.push_back(j);
        end
        n = (order.size() < P) ? order.size() : P;
        for (int p = 0; p < n; p++) begin
            e.vld[p]           = 1'b1;
            e.iprd[p*IW +: IW] = si[order[p]];
            e.data[p*DW +: DW] = sd[order[p]];
        end
        for (int i = 0; i < R; i++) m_pend[i] = 1'b0;
        for (int p = n; p < order.size(); p++) begin
            m_pend[order[p]] = 1'b1;
            m_iprd[order[p]] = si[order[p]];
            m_data[order[p]] = sd[order[p]];
            m_rob[order[p]]  = sr[order[p]];
            e.stall[order[p]] = 1'b1;
        end
        e.conflict = (order.size() > n);
        if (n > 0) m_rr = (order[n-1] + 1) % R;
        sb_q.push_back(e);
    endtask

    // One cycle of stimulus; stalled requesters drive garbage that must be ignored.
    task automatic cycle(input logic [R-1:0] mask, input bit sq, input logic [RW-1:0] sqr,
                         input bit do_rst, input bit dir);
        @(negedge clk);
        rst    = do_rst;
        sq_vld = sq;
        sq_rob = sqr;
        for (int i = 0; i < R; i++) begin
            req_iprd[i*IW +: IW] = IW'($urandom_range(0, 127));
            req_data[i*DW +: DW] = {$urandom, $urandom};
            req_rob[i*RW +: RW]  = RW'($urandom_range(0, 127));
            if (m_pend[i]) begin
                req_vld[i] = 1'($urandom_range(0, 1));
            end else begin
                req_vld[i] = mask[i];
                if (dir) req_rob[i*RW +: RW] = dir_rob[i];
            end
        end
        model_step();
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) cycle('0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        cycle('0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    // monitor: one expected record per clock edge, compared after the edge
    initial begin
        exp_t       e;
        logic [R-1:0] prev_stall;
        prev_stall = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_empty at %0t: got=no expectation expected=one per cycle", $time);
            end else begin
                e = sb_q.pop_front();
                chk("wb_vld", 256'(wb_vld), 256'(e.vld));
                for (int p = 0; p < P; p++) begin
                    if (e.vld[p]) begin
                        chk($sformatf("wb_iprd[%0d]", p), 256'(wb_iprd[p*IW +: IW]), 256'(e.iprd[p*IW +: IW]));
                        chk($sformatf("wb_data[%0d]", p), 256'(wb_data[p*DW +: DW]), 256'(e.data[p*DW +: DW]));
                    end
                end
                if (e.is_rst) begin
                    chk("rst_iprd", 256'(wb_iprd), 256'(0));
                    chk("rst_data", 256'(wb_data), 256'(0));
                end
                chk("req_stall", 256'(req_stall), 256'(e.stall));
                chk("conflict", 256'(conflict), 256'(e.conflict));
            end
            // a buffered entry must win on its first retry (ceil(6/4)-1 = 1 extra cycle)
            chk("starve", 256'(prev_stall & req_stall), 256'(0));
            prev_stall = req_stall;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; sq_vld = 1'b0; sq_rob = '0;
        req_vld = '0; req_iprd = '0; req_data = '0; req_rob = '0;
        m_rr = 0;
        for (int i = 0; i < R; i++) begin
            m_pend[i] = 1'b0; dir_rob[i] = RW'(i + 1);
        end
        model_step();
        do_reset();
        do_reset();

        // three requesters, no contention
        cycle(6'b000111, 1'b0, '0, 1'b0, 1'b0);
        idle(2);

        // single six-way burst from rr_ptr=0
        do_reset();
        cycle(6'b111111, 1'b0, '0, 1'b0, 1'b0);
        idle(3);

        // sustained six-way burst
        for (int c = 0; c < 12; c++) cycle(6'b111111, 1'b0, '0, 1'b0, 1'b0);
        idle(2);

        // req5 buffered at {0,10}, req4 buffered at {0,8}; squash at {0,8}
        do_reset();
        for (int i = 0; i < R; i++) dir_rob[i] = RW'(i + 1);
        dir_rob[4] = 7'd8;
        dir_rob[5] = 7'd10;
        cycle(6'b111111, 1'b0, '0, 1'b0, 1'b1);
        cycle(6'b000000, 1'b1, 7'd8, 1'b0, 1'b0);
        idle(2);

        // wrap: squash {1,2}; {0,60} is older, {1,3} is younger
        do_reset();
        dir_rob[0] = 7'd60;
        dir_rob[1] = 7'd67;
        cycle(6'b000011, 1'b1, 7'd66, 1'b0, 1'b1);
        idle(2);

        // reset with two buffers full, then a fresh request
        do_reset();
        cycle(6'b111111, 1'b0, '0, 1'b0, 1'b0);
        cycle(6'b000000, 1'b0, '0, 1'b1, 1'b0);
        cycle(6'b001000, 1'b0, '0, 1'b0, 1'b0);
        idle(2);

        // random traffic with occasional squash and reset
        for (int c = 0; c < 400; c++) begin
            cycle(R'($urandom), ($urandom_range(0, 5) == 0), RW'($urandom_range(0, 127)),
                  ($urandom_range(0, 63) == 0), 1'b0);
        end
        idle(3);

        @(posedge clk);
        #2;
        chk("sb_drain", 256'(sb_q.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares PORT_NUM integer physical-regfile write ports among REQ_NUM functional-unit writeback requesters (ALU, MDU, LDU).
- Drives the regfile write vector and the global bypass sources, and returns a registered per-requester stall to the FUs' wb_stall inputs.
- Holds one skid entry per requester, rotates priority round-robin, and drops squashed entries.

Parameters:
- REQ_NUM, 6, number of writeback requesters.
- PORT_NUM, 4, number of regfile write ports (PORT_NUM <= REQ_NUM).
- IPR_W, 7, physical register index width.
- XLEN, 64, data width.
- ROB_W, 6, ROB index width, excluding the wrap flag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_req_vld  in  REQ_NUM  requester i presents a writeback with rd_wen=1
- i_req_iprd  in  REQ_NUM*IPR_W  destination physical register per requester
- i_req_data  in  REQ_NUM*XLEN  result data per requester
- i_req_rob  in  REQ_NUM*(ROB_W+1)  {flag, idx} ROB position per requester
- o_req_stall  out  REQ_NUM  registered; requester must hold its output while high
- i_squash_vld  in  1  squash pulse
- i_squash_rob  in  ROB_W+1  {flag, idx} of the squash point
- o_wb_vld  out  PORT_NUM  write-port enable
- o_wb_iprd  out  PORT_NUM*IPR_W  write-port index
- o_wb_data  out  PORT_NUM*XLEN  write-port data
- o_conflict  out  1  pulse; at least one valid slot was not granted this cycle

Behaviour:
- Reset: buffers invalid, rr_ptr=0. o_req_stall, o_wb_vld and o_conflict are 0. o_wb_iprd and o_wb_data are 0.
- Slot i: the buffer entry if buf_vld[i], else the input (i_req_vld[i] && !o_req_stall[i]).
  - An input presented while o_req_stall[i]=1 is ignored; the FU holds it.
- Age rule: e is younger than s iff (e.flag==s.flag) ? e.idx>s.idx : e.idx<s.idx.
- Squash: when i_squash_vld, every slot younger than i_squash_rob is killed that cycle.
  - A killed slot is not granted and is not buffered.
  - A slot equal to the squash point survives.
- Arbitration: scan slots from rr_ptr upward, modulo REQ_NUM. The first PORT_NUM surviving valid slots win.
  - The k-th winner is placed on output port k, k = 0 upward.
- Output timing: ports are registered, so latency is 1 cycle from slot valid to o_wb_vld. Unused ports have vld=0.
- A surviving, non-granted input is written into buf[i]; buf_vld[i] is set next cycle.
- A granted buffer entry clears buf_vld[i] next cycle.
- o_req_stall[i] equals buf_vld[i] as a register, so stall rises the cycle after the loss and falls the cycle after the buffer wins.
- rr_ptr is updated to (index of last winner + 1) mod REQ_NUM. It is unchanged if there are no winners.
- o_conflict is registered and high the cycle after a surviving valid slot lost arbitration.
- Squash vs. grant in the same cycle: squash wins, so a killed slot never reaches the regfile.
  - Buffered entries are checked against the squash as well.
- Starvation bound: an entry waits at most ceil(REQ_NUM/PORT_NUM)-1 extra cycles.
- Reset mid-operation: all buffered entries are discarded.
- No duplicate-iprd checks; each iprd is produced by one FU.

Test Plan:
- Requests 0,1,2 valid, rr_ptr=0 -> next cycle o_wb_vld=4'b0111 with ports 0/1/2 = requesters 0/1/2; stall stays 0.
- All 6 valid, rr_ptr=0 -> cycle1: ports = req 0-3, o_req_stall=6'b110000, o_conflict=1, rr_ptr=4.
  - Cycle2: ports 0/1 = buffered req 4/5, stall clears in cycle3.
- Same 6-way burst repeated every cycle for 12 cycles -> every requester is granted at least once per 2 cycles, and no entry is lost or duplicated (scoreboard).
- Req 5 buffered with rob {0,10}; squash {0,8} -> buffer dropped, o_wb_vld never shows req 5, stall falls next cycle.
  - Entry at rob {0,8} survives.
- Wrap case: squash {1,2}, inputs rob {0,60} and {1,3} -> {0,60} is written, {1,3} is killed.
- rst asserted with 2 buffers full -> next cycle all outputs 0, rr_ptr=0, and a new request is granted on port 0.
